// File: rtl/transaction_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : transaction_initiator_if
// Description : Request/completion signal bundle of the coin-transfer
//               initiator; master = initiator, slave = its environment.
// Revision    : 1.0
// ============================================================================
interface transaction_initiator_if #(
    parameter int AMT_W = 8,
    parameter int TAG_W = 3
);
    localparam int WORD_W = TAG_W + AMT_W;

    logic              start;
    logic [AMT_W-1:0]  amount_in;
    logic [WORD_W-1:0] p1_balance;
    logic [WORD_W-1:0] p2_balance;
    logic [WORD_W-1:0] p1_amount;
    logic [WORD_W-1:0] p2_amount;
    logic [AMT_W-1:0]  amount_change;
    logic              complete_in;
    logic [WORD_W-1:0] p1_result_in;
    logic [WORD_W-1:0] p2_result_in;
    logic [WORD_W-1:0] p1_new;
    logic [WORD_W-1:0] p2_new;
    logic              busy;
    logic              done;
    logic              rejected;
    logic [2:0]        reason;

    modport master (
        input  start, amount_in, p1_balance, p2_balance,
        input  complete_in, p1_result_in, p2_result_in,
        output p1_amount, p2_amount, amount_change,
        output p1_new, p2_new, busy, done, rejected, reason
    );

    modport slave (
        output start, amount_in, p1_balance, p2_balance,
        output complete_in, p1_result_in, p2_result_in,
        input  p1_amount, p2_amount, amount_change,
        input  p1_new, p2_new, busy, done, rejected, reason
    );
endinterface
`default_nettype wire

// File: rtl/transaction_initiator.sv
`default_nettype none
// ============================================================================
// Module      : transaction_initiator
// Description : Validates a player1->player2 coin transfer, arms the
//               completion stage and latches its results.
//               Optional macro TXN_OVERFLOW_CHECK_EN rejects payee overflow.
// Revision    : 1.0
// ============================================================================
module transaction_initiator #(
    parameter int              AMT_W        = 8,
    parameter int              TAG_W        = 3,
    parameter logic [TAG_W-1:0] VERIFIED_TAG = 3'b110,
    parameter int              TIMEOUT      = 15
) (
    input wire clock,
    input wire resetn,
    transaction_initiator_if.master bus
);
    localparam int         WORD_W    = TAG_W + AMT_W;
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REQ    = 3'd2,
        S_DONE   = 3'd3,
        S_REJECT = 3'd4
    } state_t;

    state_t            state_q,  state_d;
    logic [WORD_W-1:0] p1_q,     p1_d;
    logic [AMT_W-1:0]  p2_val_q, p2_val_d;
    logic [AMT_W-1:0]  amt_q,    amt_d;
    logic [WORD_W-1:0] p1_new_q, p1_new_d;
    logic [WORD_W-1:0] p2_new_q, p2_new_d;
    logic [7:0]        cnt_q,    cnt_d;
    logic [2:0]        reason_q, reason_d;

    logic [AMT_W-1:0]  w_p1_exp;
    logic [AMT_W-1:0]  w_p2_exp;
    logic [TAG_W-1:0]  w_p2_tag;

    assign w_p1_exp = p1_q[AMT_W-1:0] - amt_q;
    assign w_p2_exp = p2_val_q + amt_q;

`ifdef TXN_OVERFLOW_CHECK_EN
    logic [AMT_W:0] w_p2_sum;
    assign w_p2_sum = {1'b0, p2_val_q} + {1'b0, amt_q};
`endif

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_val_d = p2_val_q;
        amt_d    = amt_q;
        p1_new_d = p1_new_q;
        p2_new_d = p2_new_q;
        cnt_d    = cnt_q;
        reason_d = reason_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    p1_d     = bus.p1_balance;
                    p2_val_d = bus.p2_balance[AMT_W-1:0];
                    amt_d    = bus.amount_in;
                    reason_d = 3'd0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (amt_q == '0) begin
                    reason_d = 3'd1;
                    state_d  = S_REJECT;
                end else if (p1_q[AMT_W-1:0] < amt_q) begin
                    reason_d = 3'd2;
                    state_d  = S_REJECT;
                end
`ifdef TXN_OVERFLOW_CHECK_EN
                else if (w_p2_sum[AMT_W]) begin
                    reason_d = 3'd3;
                    state_d  = S_REJECT;
                end
`endif
                else begin
                    cnt_d   = 8'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A completion on the final allowed cycle beats the timeout.
                if (bus.complete_in) begin
                    if ((bus.p1_result_in[AMT_W-1:0] == w_p1_exp) &&
                        (bus.p2_result_in[AMT_W-1:0] == w_p2_exp)) begin
                        p1_new_d = bus.p1_result_in;
                        p2_new_d = bus.p2_result_in;
                        state_d  = S_DONE;
                    end else begin
                        reason_d = 3'd5;
                        state_d  = S_REJECT;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == C_TIMEOUT) begin
                        reason_d = 3'd4;
                        state_d  = S_REJECT;
                    end
                end
            end
            S_DONE:   state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            p1_q     <= '0;
            p2_val_q <= '0;
            amt_q    <= '0;
            p1_new_q <= '0;
            p2_new_q <= '0;
            cnt_q    <= 8'd0;
            reason_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_val_q <= p2_val_d;
            amt_q    <= amt_d;
            p1_new_q <= p1_new_d;
            p2_new_q <= p2_new_d;
            cnt_q    <= cnt_d;
            reason_q <= reason_d;
        end
    end

    // Tag decoded straight from state so reset disarms the completion stage at once.
    assign w_p2_tag          = (state_q == S_REQ) ? VERIFIED_TAG : {TAG_W{1'b0}};
    assign bus.p2_amount     = {w_p2_tag, p2_val_q};
    assign bus.p1_amount     = p1_q;
    assign bus.amount_change = amt_q;
    assign bus.p1_new        = p1_new_q;
    assign bus.p2_new        = p2_new_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.rejected      = (state_q == S_REJECT);
    assign bus.reason        = reason_q;

endmodule
`default_nettype wire

// File: tb/tb_transaction_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_transaction_initiator
// Description : Scoreboard bench for transaction_initiator with a reactive
//               completion-stage model.
// Revision    : 1.0
// ============================================================================
module tb_transaction_initiator;
    localparam int         AMT_W   = 8;
    localparam int         TAG_W   = 3;
    localparam int         TIMEOUT = 15;
    localparam logic [2:0] VTAG    = 3'b110;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    transaction_initiator_if #(.AMT_W(AMT_W), .TAG_W(TAG_W)) bus ();

    transaction_initiator #(
        .AMT_W(AMT_W), .TAG_W(TAG_W), .VERIFIED_TAG(VTAG), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        bit          ok;
        logic [2:0]  reason;
        int          cyc;
        int          req_cycles;
        logic [10:0] p1n;
        logic [10:0] p2n;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] last_p1n = '0;
    logic [10:0] last_p2n = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // k = REQ cycle index (0-based) on which completion answers; -1 = never.
    task automatic run_txn(input logic [7:0] amt, input logic [10:0] p1, input logic [10:0] p2,
                           input int k, input logic [7:0] p1_err, input bit spurious);
        exp_t        e;
        exp_t        got_e;
        int          cyc;
        int          req_n;
        bit          seen;
        logic [7:0]  p1v, p2v, p1r, p2r;
        p1v = p1[7:0];
        p2v = p2[7:0];
        p1r = p1v - amt;
        p2r = p2v + amt;

        e.ok = 1'b0; e.reason = 3'd0; e.cyc = 2; e.req_cycles = 0;
        e.p1n = last_p1n; e.p2n = last_p2n;
        if (amt == 8'd0) e.reason = 3'd1;
        else if (p1v < amt) e.reason = 3'd2;
`ifdef TXN_OVERFLOW_CHECK_EN
        else if ((9'(p2v) + 9'(amt)) > 9'd255) e.reason = 3'd3;
`endif
        else if (k < 0 || k >= TIMEOUT) begin
            e.reason = 3'd4; e.cyc = 2 + TIMEOUT; e.req_cycles = TIMEOUT;
        end else if (p1_err != 8'd0) begin
            e.reason = 3'd5; e.cyc = 3 + k; e.req_cycles = k + 1;
        end else begin
            e.ok = 1'b1; e.cyc = 3 + k; e.req_cycles = k + 1;
            e.p1n = {p1[10:8], p1r};
            e.p2n = {3'b000, p2r};
        end
        last_p1n = e.p1n;
        last_p2n = e.p2n;
        sb.push_back(e);

        @(negedge clock);
        bus.start = 1'b1; bus.amount_in = amt; bus.p1_balance = p1; bus.p2_balance = p2;
        cyc = 0; req_n = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            bus.start = 1'b0;
            bus.complete_in = 1'b0;
            if (cyc == 1) check("busy_check", bus.busy, 1);
            if (bus.done || bus.rejected) begin
                seen = 1'b1;
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    got_e = sb.pop_front();
                    check("outcome_cyc", cyc, got_e.cyc);
                    check("done", bus.done, got_e.ok);
                    check("rejected", bus.rejected, !got_e.ok);
                    check("reason", bus.reason, got_e.reason);
                    check("req_cycles", req_n, got_e.req_cycles);
                    check("p1_new", bus.p1_new, got_e.p1n);
                    check("p2_new", bus.p2_new, got_e.p2n);
                end
            end else if (bus.p2_amount[10:8] == VTAG) begin
                if (req_n == 0) begin
                    check("arm_cyc", cyc, 2);
                    check("p2_amount_req", bus.p2_amount, {VTAG, p2v});
                    check("p1_amount_req", bus.p1_amount, p1);
                    check("amount_change", bus.amount_change, amt);
                end
                if (req_n == k) begin
                    bus.complete_in  = 1'b1;
                    bus.p1_result_in = {p1[10:8], 8'(p1r + p1_err)};
                    bus.p2_result_in = {3'b000, p2r};
                end
                req_n++;
            end else if (spurious && cyc == 1) begin
                bus.complete_in  = 1'b1;
                bus.p1_result_in = {p1[10:8], p1r};
                bus.p2_result_in = {3'b000, p2r};
            end
        end
        if (!seen) check("outcome_wait", 0, 1);
        bus.complete_in = 1'b0;
        @(negedge clock);
        check("post_busy", bus.busy, 0);
        check("post_pulse", {bus.done, bus.rejected}, 0);
        check("post_reason", bus.reason, e.reason);
        check("post_p2_tag", bus.p2_amount[10:8], 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.amount_in = '0; bus.p1_balance = '0; bus.p2_balance = '0;
        bus.complete_in = 1'b0; bus.p1_result_in = '0; bus.p2_result_in = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_pulses", {bus.done, bus.rejected}, 0);
        check("rst_reason", bus.reason, 0);
        check("rst_data", {bus.p1_amount, bus.p2_amount, bus.amount_change, bus.p1_new, bus.p2_new}, 0);
        resetn = 1'b1;

        run_txn(8'd50, 11'h0C8, 11'h032, 0,  8'd0, 1'b0);
        run_txn(8'd0,  11'h0C8, 11'h032, 0,  8'd0, 1'b1);
        run_txn(8'd11, 11'h00A, 11'h010, 0,  8'd0, 1'b0);
        run_txn(8'd11, 11'h50B, 11'h310, 2,  8'd0, 1'b0);
        run_txn(8'd10, 11'h064, 11'h0FA, 0,  8'd0, 1'b0);
        run_txn(8'd20, 11'h064, 11'h005, -1, 8'd0, 1'b0);
        run_txn(8'd20, 11'h064, 11'h005, TIMEOUT - 1, 8'd0, 1'b0);
        run_txn(8'd30, 11'h064, 11'h005, 1,  8'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_txn(8'($urandom_range(0, 255)), 11'($urandom_range(0, 2047)),
                    11'($urandom_range(0, 2047)), int'($urandom_range(0, 4)), 8'd0, 1'b0);
        end

        // Reset while the completion stage is armed.
        @(negedge clock);
        bus.start = 1'b1; bus.amount_in = 8'd5; bus.p1_balance = 11'h040; bus.p2_balance = 11'h020;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        check("mid_armed", bus.p2_amount[10:8], VTAG);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_tag", bus.p2_amount[10:8], 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_data", {bus.p1_amount, bus.amount_change, bus.p1_new, bus.p2_new, bus.reason}, 0);
        @(negedge clock);
        resetn = 1'b1;
        last_p1n = '0;
        last_p2n = '0;
        run_txn(8'd1, 11'h001, 11'h0FE, 0, 8'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
